// File: rtl/ase_channel_arbiter.sv
// Round-robin arbiter sharing one CCI-P TX channel between NUM_REQ sources.
// Multi-line writes stay locked to their owner until the last beat issues.
package ase_pkg;
  localparam int CCIP_DATA_WIDTH = 512;
  localparam logic [1:0] ASE_1CL = 2'b00;
  localparam logic [1:0] ASE_2CL = 2'b01;
  localparam logic [1:0] ASE_4CL = 2'b11;

  typedef struct packed {
    logic [1:0]  vc;
    logic        sop;
    logic        rsvd1;
    logic [1:0]  len;
    logic [3:0]  reqtype;
    logic [5:0]  rsvd2;
    logic [41:0] addr;
    logic [15:0] mdata;
  } TxHdr_t;
endpackage

module ase_channel_arbiter
  import ase_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter bit WRITE_CHANNEL = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  TxHdr_t                            req_hdr [NUM_REQ],
  input  logic [CCIP_DATA_WIDTH-1:0]        req_data [NUM_REQ],
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic                              ch_almfull,
  output TxHdr_t                            ch_txhdr,
  output logic [CCIP_DATA_WIDTH-1:0]        ch_data,
  output logic                              ch_valid,
  output logic [$clog2(NUM_REQ)-1:0]        grant_id,
  output logic [31:0]                       issued_count,
  output logic                              protocol_err
);
  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic {ARB, BURST} state_t;

  state_t           state_reg;
  logic [IDW-1:0]   rr_ptr_reg;
  logic [IDW-1:0]   owner_reg;
  logic [1:0]       beats_left_reg;

  logic [IDW-1:0]   sel_idx;
  logic             sel_ok;
  logic [IDW:0]     cand;
  logic             xfer;
  logic             is_multi;
  TxHdr_t           sel_hdr;

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] p);
    if (p == IDW'(NUM_REQ - 1)) return '0;
    else return p + 1'b1;
  endfunction

  // Scan from the highest offset down so the last hit is the nearest to rr_ptr.
  always_comb begin
    sel_idx = rr_ptr_reg;
    sel_ok  = 1'b0;
    cand    = '0;
    if (state_reg == BURST) begin
      sel_idx = owner_reg;
      sel_ok  = 1'b1;
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        cand = {1'b0, rr_ptr_reg} + (IDW+1)'(k);
        if (cand >= (IDW+1)'(NUM_REQ)) cand = cand - (IDW+1)'(NUM_REQ);
        if (req_valid[cand[IDW-1:0]]) begin
          sel_idx = cand[IDW-1:0];
          sel_ok  = 1'b1;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready[gi] = rst_n & ~ch_almfull & sel_ok & (sel_idx == IDW'(gi));
  end

  assign sel_hdr  = req_hdr[sel_idx];
  assign xfer     = req_valid[sel_idx] & req_ready[sel_idx];
  assign is_multi = WRITE_CHANNEL && ((sel_hdr.len == ASE_2CL) || (sel_hdr.len == ASE_4CL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ARB;
      rr_ptr_reg     <= '0;
      owner_reg      <= '0;
      beats_left_reg <= '0;
      ch_valid       <= 1'b0;
      ch_txhdr       <= '0;
      ch_data        <= '0;
      grant_id       <= '0;
      issued_count   <= '0;
      protocol_err   <= 1'b0;
    end else begin
      ch_valid <= xfer;
      if (xfer) begin
        ch_txhdr     <= sel_hdr;
        ch_data      <= WRITE_CHANNEL ? req_data[sel_idx] : '0;
        grant_id     <= sel_idx;
        issued_count <= issued_count + 32'd1;
        case (state_reg)
          ARB: begin
            if (is_multi) begin
              // len encodes remaining beats after this one: 2CL->1, 4CL->3
              state_reg      <= BURST;
              beats_left_reg <= sel_hdr.len;
              owner_reg      <= sel_idx;
              if (!sel_hdr.sop) protocol_err <= 1'b1;
            end else begin
              rr_ptr_reg <= wrap_inc(sel_idx);
              if (WRITE_CHANNEL && (sel_hdr.len == 2'b10)) protocol_err <= 1'b1;
            end
          end
          BURST: begin
            beats_left_reg <= beats_left_reg - 2'd1;
            if (beats_left_reg == 2'd1) begin
              state_reg  <= ARB;
              rr_ptr_reg <= wrap_inc(owner_reg);
            end
          end
          default: state_reg <= ARB;
        endcase
      end
    end
  end
endmodule
